// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM rectangle fill engine: framebuffer geometry,
// engine state encoding and the pixel-to-address mapping.
package vram_pkg;

    localparam int FB_BITS    = 8;
    localparam int ADDR_BITS  = 2 * FB_BITS;
    localparam int COLOR_BITS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        FILL    = 2'd2,
        DONE    = 2'd3
    } fill_state_t;

    // Row-major 256x256 framebuffer: the row is the high byte, the column the low byte.
    function automatic logic [ADDR_BITS-1:0] pixel_addr(input logic [FB_BITS-1:0] row,
                                                        input logic [FB_BITS-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a rising-edge
// detector that keeps tracking the input whether or not anyone is listening.
module sync_edge
    import vram_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/vram_fill.sv
// Rectangle fill engine sitting between the CPU and VRAM: idle it is a transparent
// bridge, busy it owns the VRAM port and writes one pixel per cycle.
module vram_fill
    import vram_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)
(
    input  logic        CLK,
    input  logic        I_NRESET,
    input  logic [7:0]  I_X0,
    input  logic [7:0]  I_Y0,
    input  logic [7:0]  I_W,
    input  logic [7:0]  I_H,
    input  logic [2:0]  I_COLOR,
    input  logic        I_SYNC_VSYNC,
    input  logic        I_START,
    input  logic        I_ABORT,
    input  logic        I_VGA_VSYNC,
    output logic        O_BUSY,
    output logic        O_DONE,
    input  logic [15:0] I_CPU_ADDR,
    input  logic        I_CPU_WE,
    input  logic [2:0]  I_CPU_DATA,
    output logic [2:0]  O_CPU_DATA,
    output logic        O_CPU_WAIT,
    output logic [15:0] O_VBUS_ADDR,
    output logic        O_VBUS_WE,
    output logic [2:0]  O_VBUS_DATA_TOVRAM,
    input  logic [2:0]  I_VBUS_DATA_FROMVRAM
);

    fill_state_t             state;
    logic [FB_BITS-1:0]      x0_q;
    logic [FB_BITS-1:0]      w_q;
    logic [FB_BITS-1:0]      h_q;
    logic [FB_BITS-1:0]      col_q;
    logic [FB_BITS-1:0]      row_q;
    logic [FB_BITS-1:0]      col_cnt;
    logic [FB_BITS-1:0]      row_cnt;
    logic [COLOR_BITS-1:0]   color_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    vs_rise;
    logic                    last_col;
    logic                    last_pix;
    logic                    fill_we;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vs_sync (
        .clk      (CLK),
        .rst_n    (I_NRESET),
        .async_in (I_VGA_VSYNC),
        .rise     (vs_rise)
    );

    assign last_col = (col_cnt == w_q);
    assign last_pix = last_col && (row_cnt == h_q);

    // col_q/row_q are the live pixel coordinates and wrap on their own 8 bits;
    // col_cnt/row_cnt only measure progress through the rectangle.
    always_ff @(posedge CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state   <= IDLE;
            x0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_START) begin
                        x0_q    <= I_X0;
                        w_q     <= I_W;
                        h_q     <= I_H;
                        col_q   <= I_X0;
                        row_q   <= I_Y0;
                        col_cnt <= '0;
                        row_cnt <= '0;
                        color_q <= I_COLOR;
                        busy_q  <= 1'b1;
                        state   <= I_SYNC_VSYNC ? WAIT_VS : FILL;
                    end
                end
                WAIT_VS: begin
                    if (I_ABORT) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else if (vs_rise) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (I_ABORT || last_pix) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else if (last_col) begin
                        col_q   <= x0_q;
                        col_cnt <= '0;
                        row_q   <= row_q + 8'd1;
                        row_cnt <= row_cnt + 8'd1;
                    end else begin
                        col_q   <= col_q + 8'd1;
                        col_cnt <= col_cnt + 8'd1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // An abort suppresses the write of the very cycle in which it arrives.
    assign fill_we = (state == FILL) && !I_ABORT;

    assign O_BUSY             = busy_q;
    assign O_DONE             = done_q;
    assign O_CPU_WAIT         = busy_q;
    assign O_CPU_DATA         = I_VBUS_DATA_FROMVRAM;
    assign O_VBUS_WE          = busy_q ? fill_we : I_CPU_WE;
    assign O_VBUS_ADDR        = busy_q ? pixel_addr(row_q, col_q) : I_CPU_ADDR;
    assign O_VBUS_DATA_TOVRAM = busy_q ? color_q : I_CPU_DATA;

endmodule

// File: tb/tb_vram_fill.sv
// Self-checking bench for vram_fill: directed corner cases plus randomized
// rectangles compared against a row-major pixel list built from plain arithmetic.
module tb_vram_fill;

    localparam int SYNC_STAGES = 2;

    logic        CLK = 1'b0;
    logic        I_NRESET;
    logic [7:0]  I_X0, I_Y0, I_W, I_H;
    logic [2:0]  I_COLOR;
    logic        I_SYNC_VSYNC, I_START, I_ABORT, I_VGA_VSYNC;
    logic        O_BUSY, O_DONE;
    logic [15:0] I_CPU_ADDR;
    logic        I_CPU_WE;
    logic [2:0]  I_CPU_DATA, O_CPU_DATA;
    logic        O_CPU_WAIT;
    logic [15:0] O_VBUS_ADDR;
    logic        O_VBUS_WE;
    logic [2:0]  O_VBUS_DATA_TOVRAM, I_VBUS_DATA_FROMVRAM;

    int total = 0;
    int bad   = 0;

    vram_fill #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK                  (CLK),
        .I_NRESET             (I_NRESET),
        .I_X0                 (I_X0),
        .I_Y0                 (I_Y0),
        .I_W                  (I_W),
        .I_H                  (I_H),
        .I_COLOR              (I_COLOR),
        .I_SYNC_VSYNC         (I_SYNC_VSYNC),
        .I_START              (I_START),
        .I_ABORT              (I_ABORT),
        .I_VGA_VSYNC          (I_VGA_VSYNC),
        .O_BUSY               (O_BUSY),
        .O_DONE               (O_DONE),
        .I_CPU_ADDR           (I_CPU_ADDR),
        .I_CPU_WE             (I_CPU_WE),
        .I_CPU_DATA           (I_CPU_DATA),
        .O_CPU_DATA           (O_CPU_DATA),
        .O_CPU_WAIT           (O_CPU_WAIT),
        .O_VBUS_ADDR          (O_VBUS_ADDR),
        .O_VBUS_WE            (O_VBUS_WE),
        .O_VBUS_DATA_TOVRAM   (O_VBUS_DATA_TOVRAM),
        .I_VBUS_DATA_FROMVRAM (I_VBUS_DATA_FROMVRAM)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called just after a falling edge: drives this cycle's inputs, then settles.
    task automatic applyStimulus(input logic start, input logic abort, input logic cpu_we,
                                 input logic [15:0] cpu_addr, input logic [2:0] cpu_data);
        I_START              = start;
        I_ABORT              = abort;
        I_CPU_WE             = cpu_we;
        I_CPU_ADDR           = cpu_addr;
        I_CPU_DATA           = cpu_data;
        I_VBUS_DATA_FROMVRAM = 3'($urandom);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0);
        end
    endtask

    // Cycle 0 carries the start pulse; sample k follows the k-th rising edge after it.
    // abort_at > 0 raises I_ABORT in that cycle; rise_at is the cycle vsync rises when sync=1.
    task automatic runFill(input string tag, input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] w, input logic [7:0] h, input logic [2:0] color,
                           input logic sync, input int abort_at, input logic abort_with_start,
                           input int rise_at);
        int          npix;
        int          first_write;
        int          exp_writes;
        int          exp_done;
        int          busy_cnt   = 0;
        int          wait_err   = 0;
        int          done_cnt   = 0;
        int          done_at    = -1;
        int          first_seen = -1;
        logic [15:0] exp_addr[$];
        logic [15:0] obs_addr[$];
        logic [2:0]  obs_data[$];
        logic        in_window;

        npix = (int'(w) + 1) * (int'(h) + 1);
        for (int i = 0; i < npix; i++) begin
            int r = i / (int'(w) + 1);
            int c = i % (int'(w) + 1);
            exp_addr.push_back(16'((((int'(y0) + r) % 256) * 256) + ((int'(x0) + c) % 256)));
        end
        first_write = sync ? rise_at + SYNC_STAGES + 1 : 1;
        exp_writes  = (abort_at > 0) ? abort_at - 1 : npix;
        exp_done    = (abort_at > 0) ? abort_at + 1 : first_write + npix;

        if (sync) begin
            // An edge well before the start must not release the fill.
            I_VGA_VSYNC = 1'b0;
            idleCycles(3);
            I_VGA_VSYNC = 1'b1;
            idleCycles(SYNC_STAGES + 3);
        end

        I_X0 = x0; I_Y0 = y0; I_W = w; I_H = h; I_COLOR = color; I_SYNC_VSYNC = sync;
        @(negedge CLK);
        applyStimulus(1'b1, abort_with_start, 1'b0, 16'h0000, 3'd0);

        for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
            @(negedge CLK);
            if (sync && cyc == rise_at - 3) I_VGA_VSYNC = 1'b0;
            if (sync && cyc == rise_at)     I_VGA_VSYNC = 1'b1;
            in_window = (cyc <= exp_done);
            applyStimulus(in_window && ($urandom_range(0, 3) == 0), (cyc == abort_at),
                          in_window && ($urandom_range(0, 1) == 1), 16'($urandom), 3'($urandom));
            if (O_BUSY === 1'b1) busy_cnt++;
            if (O_CPU_WAIT !== O_BUSY) wait_err++;
            if (O_BUSY === 1'b1 && O_VBUS_WE === 1'b1) begin
                if (obs_addr.size() == 0) first_seen = cyc;
                obs_addr.push_back(O_VBUS_ADDR);
                obs_data.push_back(O_VBUS_DATA_TOVRAM);
            end
            if (O_DONE === 1'b1) begin
                if (done_cnt == 0) done_at = cyc;
                done_cnt++;
            end
        end

        checkOutput({tag, " writes"}, obs_addr.size(), exp_writes);
        for (int i = 0; i < exp_writes && i < obs_addr.size(); i++) begin
            checkOutput($sformatf("%s addr[%0d]", tag, i), obs_addr[i], exp_addr[i]);
            checkOutput($sformatf("%s data[%0d]", tag, i), obs_data[i], color);
        end
        if (exp_writes > 0) checkOutput({tag, " first_write_cycle"}, first_seen, first_write);
        checkOutput({tag, " done_pulses"}, done_cnt, 1);
        checkOutput({tag, " done_cycle"}, done_at, exp_done);
        checkOutput({tag, " busy_cycles"}, busy_cnt, exp_done);
        checkOutput({tag, " wait_tracks_busy"}, wait_err, 0);
        checkOutput({tag, " idle_after"}, O_BUSY, 1'b0);
    endtask

    initial begin
        I_NRESET = 1'b0;
        I_X0 = '0; I_Y0 = '0; I_W = '0; I_H = '0; I_COLOR = '0;
        I_SYNC_VSYNC = 1'b0; I_START = 1'b0; I_ABORT = 1'b0; I_VGA_VSYNC = 1'b0;
        I_CPU_ADDR = '0; I_CPU_WE = 1'b0; I_CPU_DATA = '0; I_VBUS_DATA_FROMVRAM = '0;
        idleCycles(3);
        checkOutput("reset busy", O_BUSY, 1'b0);
        checkOutput("reset done", O_DONE, 1'b0);
        checkOutput("reset wait", O_CPU_WAIT, 1'b0);
        checkOutput("reset we", O_VBUS_WE, 1'b0);
        @(negedge CLK);
        I_NRESET = 1'b1;
        idleCycles(2);

        $display("[TB] idle CPU pass-through");
        @(negedge CLK);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 3'd3);
        checkOutput("idle addr", O_VBUS_ADDR, 16'h1234);
        checkOutput("idle we", O_VBUS_WE, 1'b1);
        checkOutput("idle data", O_VBUS_DATA_TOVRAM, 3'd3);
        checkOutput("idle wait", O_CPU_WAIT, 1'b0);
        checkOutput("idle rdata", O_CPU_DATA, I_VBUS_DATA_FROMVRAM);
        for (int k = 0; k < 3; k++) begin
            logic [15:0] a = 16'($urandom);
            logic [2:0]  d = 3'($urandom);
            logic        we = 1'($urandom);
            @(negedge CLK);
            applyStimulus(1'b0, 1'b0, we, a, d);
            checkOutput("idle rnd addr", O_VBUS_ADDR, a);
            checkOutput("idle rnd we", O_VBUS_WE, we);
            checkOutput("idle rnd data", O_VBUS_DATA_TOVRAM, d);
        end

        $display("[TB] directed fills");
        runFill("basic", 8'd10, 8'd20, 8'd2, 8'd1, 3'd5, 1'b0, 0, 1'b0, 0);
        runFill("wrap", 8'hFE, 8'hFF, 8'd3, 8'd1, 3'd2, 1'b0, 0, 1'b0, 0);
        runFill("single", 8'hFF, 8'hFF, 8'd0, 8'd0, 3'd7, 1'b0, 0, 1'b0, 0);
        runFill("vsync", 8'd40, 8'd3, 8'd1, 8'd1, 3'd6, 1'b1, 0, 1'b0, 7);
        runFill("abort", 8'd0, 8'd0, 8'd3, 8'd3, 3'd1, 1'b0, 4, 1'b0, 0);
        runFill("start_abort", 8'd5, 8'd6, 8'd1, 8'd0, 3'd4, 1'b0, 0, 1'b1, 0);

        $display("[TB] reset during fill");
        I_X0 = 8'd1; I_Y0 = 8'd1; I_W = 8'd3; I_H = 8'd3; I_COLOR = 3'd3; I_SYNC_VSYNC = 1'b0;
        @(negedge CLK);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 3'd0);
        idleCycles(4);
        checkOutput("mid fill we", O_VBUS_WE, 1'b1);
        @(negedge CLK);
        I_NRESET = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'hBEEF, 3'd0);
        checkOutput("rst busy", O_BUSY, 1'b0);
        checkOutput("rst we", O_VBUS_WE, 1'b0);
        checkOutput("rst wait", O_CPU_WAIT, 1'b0);
        checkOutput("rst done", O_DONE, 1'b0);
        checkOutput("rst addr", O_VBUS_ADDR, 16'hBEEF);
        begin
            int done_seen = 0;
            for (int k = 0; k < 6; k++) begin
                if (k == 3) I_NRESET = 1'b1;
                @(negedge CLK);
                applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0);
                if (O_DONE !== 1'b0 || O_BUSY !== 1'b0) done_seen++;
            end
            checkOutput("rst no done", done_seen, 0);
        end
        runFill("after_reset", 8'd100, 8'd200, 8'd2, 8'd2, 3'd5, 1'b0, 0, 1'b0, 0);

        $display("[TB] randomized fills");
        for (int t = 0; t < 8; t++) begin
            logic [7:0] w = 8'($urandom_range(0, 5));
            logic [7:0] h = 8'($urandom_range(0, 4));
            int         npix = (int'(w) + 1) * (int'(h) + 1);
            logic       sync = (t % 3 == 1);
            int         abort_at = 0;
            if (t % 3 == 2 && npix >= 2) abort_at = $urandom_range(2, npix);
            runFill($sformatf("rnd%0d", t), 8'($urandom), 8'($urandom), w, h, 3'($urandom),
                    sync, abort_at, 1'b0, $urandom_range(5, 9));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
